// File: rtl/npu_cube_mac_seq_if.sv
// ==== npu_cube_mac_seq_if : job / operand / add-tree / result bundle for the MAC sequencer ====
// ==== rev 1.0                                                                             ====
`timescale 1ns/1ps
`default_nettype none

interface npu_cube_mac_seq_if #(
  parameter int DWA              = 8,
  parameter int DWB_CODE         = 12,
  parameter int NPU_CUBE_MAC_NUM = 8,
  parameter int DWS              = 21,
  parameter int ACC_W            = 32,
  parameter int LEN_W            = 8
) ();
  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [LEN_W-1:0]                     cfg_len;
  logic                                 cfg_signed;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [DWA*NPU_CUBE_MAC_NUM-1:0]      in_data;
  logic [DWB_CODE*NPU_CUBE_MAC_NUM-1:0] in_para;
  logic [DWA*NPU_CUBE_MAC_NUM-1:0]      tree_data;
  logic [DWB_CODE*NPU_CUBE_MAC_NUM-1:0] tree_para;
  logic                                 tree_is_signed;
  logic                                 tree_valid;
  logic [DWS-1:0]                       tree_sum;
  logic                                 res_valid;
  logic                                 res_ready;
  logic [ACC_W-1:0]                     res_data;
  logic                                 busy;

  // Sequencer side
  modport slave (
    input  cfg_valid, cfg_len, cfg_signed, in_valid, in_data, in_para, tree_sum, res_ready,
    output cfg_ready, in_ready, tree_data, tree_para, tree_is_signed, tree_valid,
           res_valid, res_data, busy
  );

  // Operand buffers / add tree / result consumer side
  modport master (
    output cfg_valid, cfg_len, cfg_signed, in_valid, in_data, in_para, tree_sum, res_ready,
    input  cfg_ready, in_ready, tree_data, tree_para, tree_is_signed, tree_valid,
           res_valid, res_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/npu_cube_mac_seq.sv
// ==== npu_cube_mac_seq : job sequencer feeding the cube MAC add tree, accumulates one result/job ====
// ==== rev 1.0                                                                                   ====
`timescale 1ns/1ps
`default_nettype none

module npu_cube_mac_seq #(
  parameter int DWA              = 8,
  parameter int DWB_CODE         = 12,
  parameter int NPU_CUBE_MAC_NUM = 8,
  parameter int DWS              = 21,
  parameter int ACC_W            = 32,
  parameter int TREE_LAT         = 2,
  parameter int LEN_W            = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  npu_cube_mac_seq_if.slave     mac_io
);

  localparam int DW = DWA * NPU_CUBE_MAC_NUM;
  localparam int PW = DWB_CODE * NPU_CUBE_MAC_NUM;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic [LEN_W-1:0]    len_q,    len_d;
  logic                signed_q, signed_d;
  logic [LEN_W:0]      issue_q,  issue_d;
  logic [LEN_W:0]      retire_q, retire_d;
  logic [ACC_W-1:0]    acc_q,    acc_d;
  logic [DW-1:0]       tdata_q,  tdata_d;
  logic [PW-1:0]       tpara_q,  tpara_d;
  logic                tvalid_q, tvalid_d;
  logic [TREE_LAT-1:0] vpipe_q,  vpipe_d;

  logic                accept;
  logic                retire;
  logic [ACC_W-1:0]    sum_ext;

  assign accept  = mac_io.in_valid && (state_q == S_RUN);
  // The head of the valid shift marks the cycle in which tree_sum belongs to one of our beats.
  assign retire  = vpipe_q[TREE_LAT-1];
  assign sum_ext = {{(ACC_W-DWS){mac_io.tree_sum[DWS-1] & signed_q}}, mac_io.tree_sum};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    signed_d = signed_q;
    issue_d  = issue_q;
    retire_d = retire_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tpara_d  = tpara_q;
    tvalid_d = accept;
    vpipe_d  = (vpipe_q << 1) | TREE_LAT'(tvalid_q);

    if (accept) begin
      tdata_d = mac_io.in_data;
      tpara_d = mac_io.in_para;
    end

    if (retire) begin
      acc_d    = acc_q + sum_ext;
      retire_d = retire_q + (LEN_W+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (mac_io.cfg_valid) begin
          len_d    = mac_io.cfg_len;
          signed_d = mac_io.cfg_signed;
          acc_d    = '0;
          issue_d  = '0;
          retire_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          issue_d = issue_q + (LEN_W+1)'(1);
          if (issue_q == {1'b0, len_q}) begin
            state_d = S_DRAIN;
          end
        end
      end
      // Leave DRAIN on the same edge the final sum lands so the result is presented immediately.
      S_DRAIN: begin
        if (retire && (retire_q == {1'b0, len_q})) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (mac_io.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      signed_q <= 1'b0;
      issue_q  <= '0;
      retire_q <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tpara_q  <= '0;
      tvalid_q <= 1'b0;
      vpipe_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      signed_q <= signed_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tpara_q  <= tpara_d;
      tvalid_q <= tvalid_d;
      vpipe_q  <= vpipe_d;
    end
  end

  assign mac_io.cfg_ready      = (state_q == S_IDLE);
  assign mac_io.in_ready       = (state_q == S_RUN);
  assign mac_io.tree_data      = tdata_q;
  assign mac_io.tree_para      = tpara_q;
  assign mac_io.tree_is_signed = signed_q;
  assign mac_io.tree_valid     = tvalid_q;
  assign mac_io.res_valid      = (state_q == S_DONE);
  assign mac_io.res_data       = acc_q;
  assign mac_io.busy           = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_npu_cube_mac_seq.sv
// ==== tb_npu_cube_mac_seq : directed + randomized self-checking bench for npu_cube_mac_seq ====
// ==== rev 1.0                                                                              ====
`timescale 1ns/1ps
`default_nettype none

module tb_npu_cube_mac_seq;
  localparam int DWA = 8, DWB_CODE = 12, NPU_CUBE_MAC_NUM = 8, DWS = 21, ACC_W = 32;
  localparam int TREE_LAT = 2, LEN_W = 8;
  localparam int DW = DWA * NPU_CUBE_MAC_NUM, PW = DWB_CODE * NPU_CUBE_MAC_NUM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npu_cube_mac_seq_if #(.DWA(DWA), .DWB_CODE(DWB_CODE), .NPU_CUBE_MAC_NUM(NPU_CUBE_MAC_NUM),
                        .DWS(DWS), .ACC_W(ACC_W), .LEN_W(LEN_W)) mac_if ();

  npu_cube_mac_seq #(.DWA(DWA), .DWB_CODE(DWB_CODE), .NPU_CUBE_MAC_NUM(NPU_CUBE_MAC_NUM),
                     .DWS(DWS), .ACC_W(ACC_W), .TREE_LAT(TREE_LAT), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mac_io (mac_if)
  );

  // Add-tree stand-in: each tree_valid consumes the next scripted sum and presents it two
  // cycles later; every other cycle carries random junk the sequencer must ignore.
  logic [DWS-1:0] sums[$];
  int             sptr = 0;
  logic [DWS-1:0] stage = '0;
  logic [DW-1:0]  got_d[$];
  logic [PW-1:0]  got_p[$];
  bit             got_s[$];
  int             tv_cyc[$];

  always @(posedge clk) begin
    mac_if.tree_sum <= stage;
    if (!rst_n) begin
      sptr = sums.size();
      stage <= DWS'($urandom);
    end else if (mac_if.tree_valid) begin
      got_d.push_back(mac_if.tree_data);
      got_p.push_back(mac_if.tree_para);
      got_s.push_back(mac_if.tree_is_signed);
      tv_cyc.push_back(cyc);
      stage <= (sptr < sums.size()) ? sums[sptr] : DWS'($urandom);
      sptr++;
    end else begin
      stage <= DWS'($urandom);
    end
  end

  int            n_chk = 0, n_pass = 0;
  logic [DW-1:0] exp_d[$];
  logic [PW-1:0] exp_p[$];
  int            gptr = 0;
  bit            cur_sgn = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    n_chk++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Reference: dot-product is the plain integer sum of the per-beat sums, wrapped to ACC_W.
  function automatic logic [ACC_W-1:0] ref_acc(input logic [DWS-1:0] s[$], input bit sgn);
    longint a = 0;
    foreach (s[i]) begin
      longint v = longint'(s[i]);
      if (sgn && v >= (longint'(1) << (DWS-1))) v = v - (longint'(1) << DWS);
      a = a + v;
    end
    return a[ACC_W-1:0];
  endfunction

  task automatic start_job(input int len, input bit sgn);
    int t = 0;
    @(negedge clk);
    while (!mac_if.cfg_ready && t < 200) begin @(negedge clk); t++; end
    if (!mac_if.cfg_ready) timeout("cfg_accept");
    mac_if.cfg_valid  = 1'b1;
    mac_if.cfg_len    = LEN_W'(len);
    mac_if.cfg_signed = sgn;
    cur_sgn           = sgn;
    @(posedge clk); #1;
    mac_if.cfg_valid  = 1'b0;
  endtask

  task automatic feed_beat(output int acc_cyc);
    int t = 0;
    @(negedge clk);
    mac_if.in_valid = 1'b1;
    mac_if.in_data  = {$urandom, $urandom};
    mac_if.in_para  = {$urandom, $urandom, $urandom};
    while (!mac_if.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!mac_if.in_ready) begin
      timeout("beat_accept");
      mac_if.in_valid = 1'b0;
      acc_cyc = cyc;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    exp_d.push_back(mac_if.in_data);
    exp_p.push_back(mac_if.in_para);
    mac_if.in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, output int first_cyc);
    int t = 0;
    @(negedge clk);
    while (!mac_if.res_valid && t < 2000) begin @(negedge clk); t++; end
    first_cyc = cyc;
    if (!mac_if.res_valid) timeout({tag, "_res_valid"});
  endtask

  task automatic check_beats(input string tag);
    int bad = 0;
    int n   = got_d.size() - gptr;
    chk({tag, "_beat_count"}, 128'(n), 128'(exp_d.size()));
    for (int i = 0; i < n && i < exp_d.size(); i++) begin
      if (got_d[gptr+i] !== exp_d[i] || got_p[gptr+i] !== exp_p[i] || got_s[gptr+i] !== cur_sgn)
        bad++;
    end
    chk({tag, "_beat_content"}, 128'(bad), 128'(0));
    gptr = got_d.size();
    exp_d.delete();
    exp_p.delete();
  endtask

  task automatic finish_job(input string tag, input logic [ACC_W-1:0] exp, input int hold,
                            output int first_cyc);
    wait_res(tag, first_cyc);
    chk({tag, "_res_data"}, 128'(mac_if.res_data), 128'(exp));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, "_res_hold"}, 128'({mac_if.res_valid, mac_if.res_data}), 128'({1'b1, exp}));
    end
    mac_if.res_ready = 1'b1;
    @(posedge clk); #1;
    mac_if.res_ready = 1'b0;
    check_beats(tag);
  endtask

  initial begin
    int             c, fc, base, len, gap, hold;
    bit             sgn;
    logic [DWS-1:0] js[$];
    logic [ACC_W-1:0] expv;

    mac_if.cfg_valid = 1'b0; mac_if.cfg_len = '0; mac_if.cfg_signed = 1'b0;
    mac_if.in_valid  = 1'b0; mac_if.in_data = '0; mac_if.in_para    = '0;
    mac_if.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_flags", {mac_if.cfg_ready, mac_if.in_ready, mac_if.busy}, 3'b100);
    chk("rst_res",  {mac_if.res_valid, mac_if.res_data}, '0);
    chk("rst_tree", {mac_if.tree_valid, mac_if.tree_is_signed, mac_if.tree_data, mac_if.tree_para}, '0);
    rst_n = 1'b1;

    // 1: single unsigned beat, latency from accept edge to first res_valid sample
    sums.push_back(21'd100);
    base = tv_cyc.size();
    start_job(0, 1'b0);
    feed_beat(c);
    finish_job("t1", 32'd100, 0, fc);
    // accept edge c; acc lands TREE_LAT+1 edges later and res_valid is seen right after it
    chk("t1_latency", 128'(fc - c), 128'(TREE_LAT + 1));
    chk("t1_pulses", 128'(tv_cyc.size() - base), 128'(1));

    // 2: signed sums -5, 3, 1
    sums.push_back(21'h1FFFFB); sums.push_back(21'd3); sums.push_back(21'd1);
    start_job(2, 1'b1);
    repeat (3) feed_beat(c);
    chk("t2_is_signed", mac_if.tree_is_signed, 1'b1);
    finish_job("t2", 32'hFFFF_FFFF, 1, fc);

    // 3: 256 back-to-back beats of the largest unsigned sum
    for (int i = 0; i < 256; i++) sums.push_back(21'h1FFFFF);
    base = tv_cyc.size();
    start_job(255, 1'b0);
    repeat (256) feed_beat(c);
    finish_job("t3", 32'h1FFF_FF00, 0, fc);
    chk("t3_pulses", 128'(tv_cyc.size() - base), 128'(256));
    chk("t3_no_bubbles", 128'(tv_cyc[base+255] - tv_cyc[base]), 128'(255));

    // 4: three idle cycles between beats must show up as the same gap on tree_valid
    sums.push_back(21'd7); sums.push_back(21'd9);
    base = tv_cyc.size();
    start_job(1, 1'b0);
    feed_beat(c);
    repeat (3) @(posedge clk);
    feed_beat(c);
    finish_job("t4", 32'd16, 0, fc);
    chk("t4_gap", 128'(tv_cyc[base+1] - tv_cyc[base]), 128'(4));

    // 5: result held under back-pressure while a new job is already requested
    sums.push_back(21'd50);
    start_job(0, 1'b0);
    feed_beat(c);
    wait_res("t5", fc);
    mac_if.cfg_valid = 1'b1; mac_if.cfg_len = '0; mac_if.cfg_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold", {mac_if.res_valid, mac_if.cfg_ready, mac_if.res_data}, {2'b10, 32'd50});
      @(negedge clk);
    end
    check_beats("t5a");
    sums.push_back(21'd77);
    cur_sgn = 1'b0;
    mac_if.res_ready = 1'b1;
    @(posedge clk); #1;
    mac_if.res_ready = 1'b0;
    @(negedge clk);
    chk("t5_idle_after_ready", {mac_if.res_valid, mac_if.cfg_ready, mac_if.busy}, 3'b010);
    @(posedge clk); #1;
    mac_if.cfg_valid = 1'b0;
    @(negedge clk);
    chk("t5_accept_next", {mac_if.busy, mac_if.in_ready}, 2'b11);
    feed_beat(c);
    finish_job("t5b", 32'd77, 0, fc);

    // 6: reset with two beats in flight, then a clean job
    sums.push_back(21'd1000); sums.push_back(21'd2000);
    sums.push_back(21'd3000); sums.push_back(21'd4000);
    start_job(3, 1'b1);
    repeat (2) feed_beat(c);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_flags", {mac_if.cfg_ready, mac_if.in_ready, mac_if.busy, mac_if.res_valid}, 4'b1000);
    chk("t6_rst_tree", {mac_if.tree_valid, mac_if.tree_is_signed, mac_if.tree_data, mac_if.tree_para}, '0);
    chk("t6_rst_res_data", mac_if.res_data, '0);
    rst_n = 1'b1;
    gptr = got_d.size();
    exp_d.delete();
    exp_p.delete();
    sums.push_back(21'd4);
    start_job(0, 1'b0);
    feed_beat(c);
    finish_job("t6", 32'd4, 0, fc);

    // Randomized jobs against the arithmetic reference
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(0, 20);
      sgn = 1'($urandom_range(0, 1));
      js.delete();
      for (int b = 0; b <= len; b++) js.push_back(DWS'($urandom));
      foreach (js[i]) sums.push_back(js[i]);
      expv = ref_acc(js, sgn);
      base = tv_cyc.size();
      start_job(len, sgn);
      for (int b = 0; b <= len; b++) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        repeat (gap) @(posedge clk);
        feed_beat(c);
      end
      hold = $urandom_range(0, 3);
      finish_job("rnd", expv, hold, fc);
      chk("rnd_pulses", 128'(tv_cyc.size() - base), 128'(len + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
